// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the issuing pipeline and the multiply/divide unit.
interface mult_div_unit_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, rs_data, rt_data,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, rs_data, rt_data,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU with HI/LO and MTHI/MTLO; divider present only with MDU_DIV_EN.
// Latency: 34 cycles start-to-result (done pulses the cycle after the FIX edge); MTHI/MTLO write in 1 cycle.
// Backpressure: none queued; start is sampled only in IDLE and dropped while busy.
module mult_div_unit (
    input  logic            clk,
    input  logic            reset,
    mult_div_unit_if.slave  bus
);
`ifdef MDU_DIV_EN
    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, FIX = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, FIX = 2'd3} state_t;
`endif

    state_t      state;
    logic [4:0]  count;
    logic [31:0] mcand;      // multiplicand magnitude, or divisor magnitude
    logic [63:0] acc;        // mul: {partial, multiplier}; div: {remainder, quotient}
    logic        neg_res;    // product sign, or quotient sign
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        busy_q;
    logic        done_q;
`ifdef MDU_DIV_EN
    logic        is_div;
    logic        neg_rem;
    logic        div_zero;
`endif

    logic        signed_op;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_abs;
    logic [31:0] b_abs;
    logic [32:0] mul_sum;
    logic [63:0] prod_fix;

    always_comb begin
        signed_op = (bus.op == 3'b000) || (bus.op == 3'b010);
        a_neg     = signed_op & bus.rs_data[31];
        b_neg     = signed_op & bus.rt_data[31];
        a_abs     = a_neg ? -bus.rs_data : bus.rs_data;
        b_abs     = b_neg ? -bus.rt_data : bus.rt_data;
        mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mcand} : 33'd0);
        prod_fix  = neg_res ? -acc : acc;
    end

`ifdef MDU_DIV_EN
    logic [32:0] div_shift;
    logic        div_ge;
    logic [31:0] div_rem;

    // Restoring step: the remainder stays below the divisor, so 32 bits of the difference suffice.
    always_comb begin
        div_shift = {acc[63:32], acc[31]};
        div_ge    = div_shift >= {1'b0, mcand};
        div_rem   = div_shift[31:0] - mcand;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            count   <= 5'd0;
            mcand   <= 32'd0;
            acc     <= 64'd0;
            neg_res <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef MDU_DIV_EN
            is_div   <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        case (bus.op)
                            3'b000, 3'b001: begin
                                state   <= MUL;
                                busy_q  <= 1'b1;
                                count   <= 5'd0;
                                mcand   <= a_abs;
                                acc     <= {32'd0, b_abs};
                                neg_res <= a_neg ^ b_neg;
`ifdef MDU_DIV_EN
                                is_div  <= 1'b0;
`endif
                            end
`ifdef MDU_DIV_EN
                            3'b010, 3'b011: begin
                                state    <= DIV;
                                busy_q   <= 1'b1;
                                count    <= 5'd0;
                                mcand    <= b_abs;
                                acc      <= {32'd0, a_abs};
                                neg_res  <= a_neg ^ b_neg;
                                neg_rem  <= a_neg;
                                div_zero <= (bus.rt_data == 32'd0);
                                is_div   <= 1'b1;
                            end
`endif
                            3'b100:  hi_q <= bus.rs_data;
                            3'b101:  lo_q <= bus.rs_data;
                            default: ;
                        endcase
                    end
                end
                MUL: begin
                    acc   <= {mul_sum, acc[31:1]};
                    count <= count + 5'd1;
                    if (count == 5'd31) state <= FIX;
                end
`ifdef MDU_DIV_EN
                DIV: begin
                    acc   <= {(div_ge ? div_rem : div_shift[31:0]), acc[30:0], div_ge};
                    count <= count + 5'd1;
                    if (count == 5'd31) state <= FIX;
                end
`endif
                FIX: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
`ifdef MDU_DIV_EN
                    if (is_div) begin
                        // Divide-by-zero forces an all-ones quotient regardless of operand signs.
                        lo_q <= div_zero ? 32'hFFFF_FFFF : (neg_res ? -acc[31:0] : acc[31:0]);
                        hi_q <= neg_rem ? -acc[63:32] : acc[63:32];
                    end else begin
                        {hi_q, lo_q} <= prod_fix;
                    end
`else
                    {hi_q, lo_q} <= prod_fix;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed plus randomized bench for mult_div_unit against an arithmetic reference model.
`timescale 1ns/1ps
module tb_mult_div_unit;
`ifdef MDU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    mult_div_unit_if bus();

    mult_div_unit dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Reference state: what HI/LO/busy/done must be after each rising edge.
    logic        m_busy;
    logic        m_done;
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic [63:0] m_pend;
    int          m_cnt;

    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        int                 ia;
        int                 ib;
        int                 iq;
        int                 ir;
        logic [63:0]        r;
        r = 64'd0;
        case (op)
            3'd0: begin
                sa = {{32{a[31]}}, a};
                sb = {{32{b[31]}}, b};
                r  = sa * sb;
            end
            3'd1: r = {32'd0, a} * {32'd0, b};
            3'd2: begin
                if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'd0, 32'h8000_0000};
                else begin
                    ia = a;
                    ib = b;
                    iq = ia / ib;
                    ir = ia % ib;
                    r  = {ir, iq};
                end
            end
            3'd3: r = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
            default: r = 64'd0;
        endcase
        return r;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_hi   = 32'd0;
            m_lo   = 32'd0;
            m_cnt  = 0;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                m_cnt++;
                if (m_cnt == 33) begin
                    m_busy       = 1'b0;
                    m_done       = 1'b1;
                    {m_hi, m_lo} = m_pend;
                end
            end else if (bus.start) begin
                if (bus.op == 3'd0 || bus.op == 3'd1 || (DIV_EN && (bus.op == 3'd2 || bus.op == 3'd3))) begin
                    m_busy = 1'b1;
                    m_cnt  = 0;
                    m_pend = ref_result(bus.op, bus.rs_data, bus.rt_data);
                end else if (bus.op == 3'd4) begin
                    m_hi = bus.rs_data;
                end else if (bus.op == 3'd5) begin
                    m_lo = bus.rs_data;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_busy", {31'd0, bus.busy}, {31'd0, m_busy});
            check("cyc_done", {31'd0, bus.done}, {31'd0, m_done});
            check("cyc_hi", bus.hi, m_hi);
            check("cyc_lo", bus.lo, m_lo);
        end
    end

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Called at a falling edge; start is sampled on the next rising edge (edge 0).
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start   = 1'b1;
        bus.op      = op;
        bus.rs_data = a;
        bus.rt_data = b;
        @(negedge clk);
        bus.start   = 1'b0;
        bus.rs_data = $urandom;
        bus.rt_data = $urandom;
    endtask

    task automatic wait_done(input string name, output int n);
        n = 0;
        while (bus.done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'd0, bus.done}, 32'd1);
    endtask

    task automatic expect_hilo(input string name, input logic [31:0] hi_exp, input logic [31:0] lo_exp);
        check({name, "_hi"}, bus.hi, hi_exp);
        check({name, "_lo"}, bus.lo, lo_exp);
        check({name, "_model_hi"}, m_hi, hi_exp);
        check({name, "_model_lo"}, m_lo, lo_exp);
    endtask

    int n;

    initial begin
        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.op      = 3'd0;
        bus.rs_data = 32'd0;
        bus.rt_data = 32'd0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        expect_hilo("rst", 32'd0, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        do_op(3'd0, 32'hFFFF_FFFF, 32'h0000_0002);
        check("mult_busy_edge0", {31'd0, bus.busy}, 32'd1);
        wait_done("mult_done", n);
        check("mult_latency", n, 33);
        expect_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFE);

        // Issued in the done cycle: must be accepted immediately.
        do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu_busy_edge0", {31'd0, bus.busy}, 32'd1);
        wait_done("multu_done", n);
        expect_hilo("multu", 32'hFFFF_FFFE, 32'h0000_0001);
        @(negedge clk);

        do_op(3'd4, 32'h1234_5678, 32'd0);
        check("mthi_busy", {31'd0, bus.busy}, 32'd0);
        check("mthi_hi", bus.hi, 32'h1234_5678);
        do_op(3'd5, 32'h9ABC_DEF0, 32'd0);
        check("mtlo_done", {31'd0, bus.done}, 32'd0);
        expect_hilo("mtlo", 32'h1234_5678, 32'h9ABC_DEF0);

        if (DIV_EN) begin
            do_op(3'd2, 32'hFFFF_FFF9, 32'h0000_0002);
            wait_done("div_done", n);
            check("div_latency", n, 33);
            expect_hilo("div_neg7", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
            do_op(3'd3, 32'h0000_0010, 32'd0);
            wait_done("divu0_done", n);
            check("divu0_latency", n, 33);
            expect_hilo("divu0", 32'h0000_0010, 32'hFFFF_FFFF);
            do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
            wait_done("divovf_done", n);
            expect_hilo("divovf", 32'h0000_0000, 32'h8000_0000);
        end else begin
            do_op(3'd2, 32'd8, 32'd2);
            check("nodiv_busy", {31'd0, bus.busy}, 32'd0);
            repeat (36) @(negedge clk);
            expect_hilo("nodiv", 32'h1234_5678, 32'h9ABC_DEF0);
        end

        do_op(3'd6, 32'hDEAD_BEEF, 32'd1);
        check("rsvd_busy", {31'd0, bus.busy}, 32'd0);
        @(negedge clk);

        // Second start mid-operation is dropped; a third operation is killed by reset.
        do_op(3'd0, 32'd3, 32'd4);
        repeat (9) @(negedge clk);
        do_op(3'd3, 32'd100, 32'd7);
        wait_done("ignore_done", n);
        check("ignore_latency", n, 23);
        expect_hilo("mult3x4", 32'd0, 32'h0000_000C);
        do_op(3'd0, 32'h0001_0000, 32'h0001_0000);
        repeat (19) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_done", {31'd0, bus.done}, 32'd0);
        expect_hilo("abort", 32'd0, 32'd0);
        repeat (20) @(negedge clk);

        for (int c = 0; c < 3000; c++) begin
            reset       = ($urandom_range(0, 399) == 0);
            bus.start   = ($urandom_range(0, 2) == 0);
            bus.op      = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
            bus.rs_data = pick();
            bus.rt_data = pick();
            @(negedge clk);
        end
        reset     = 1'b0;
        bus.start = 1'b0;
        repeat (40) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
- REQ-001: Parameters SHALL be none; datapath width is fixed at 32 bits.
- REQ-002: clk  input  1  system clock; all state changes on rising edge.
- REQ-003: reset  input  1  synchronous, active-high reset.
- REQ-004: start  input  1  request strobe; sampled only in IDLE.
- REQ-005: op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 reserved.
- REQ-006: rs_data  input  32  operand A (multiplicand/dividend/MTHI-MTLO source), from register-file read port 1.
- REQ-007: rt_data  input  32  operand B (multiplier/divisor), from register-file read port 2.
- REQ-008: busy  output  1  high while an iterative operation is in flight.
- REQ-009: done  output  1  one-cycle pulse when HI/LO hold a new MULT/DIV result.
- REQ-010: hi  output  32  HI register (product upper word / remainder).
- REQ-011: lo  output  32  LO register (product lower word / quotient).

Function
- REQ-012: FSM states SHALL be IDLE, MUL, DIV, FIX; only IDLE accepts start.
- REQ-013: Edge 0 = edge where start=1 in IDLE; operands SHALL be latched at edge 0 and later rs_data/rt_data changes ignored.
- REQ-014: MULT/MULTU/DIV/DIVU at edge 0 SHALL enter MUL or DIV; busy=1 from edge 0 until edge 33.
- REQ-015: MUL/DIV SHALL do one radix-2 step per edge (edges 1..32) on operand magnitudes (signed ops) or raw values (unsigned ops), counter 0..31.
- REQ-016: FIX (edge 33) SHALL apply sign correction, write HI/LO, clear busy, set done=1 for exactly the cycle after edge 33.
- REQ-017: MULT/MULTU SHALL give {hi,lo} = full 64-bit product, two's-complement for MULT.
- REQ-018: DIV SHALL truncate toward zero: lo=quotient, hi=remainder with dividend's sign; DIVU unsigned.
- REQ-019: Divisor 0 SHALL give lo=0xFFFFFFFF, hi=dividend, same 34-cycle latency.
- REQ-020: DIV 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000, hi=0x00000000.
- REQ-021: MTHI/MTLO at edge 0 SHALL write rs_data to hi/lo at that edge; busy and done stay 0; FSM stays IDLE.
- REQ-022: Reserved op with start=1 SHALL be ignored (no state, HI/LO change).
- REQ-023: start while busy=1 SHALL be ignored, not queued.
- REQ-024: hi/lo SHALL hold their values between writes; a new MULT/DIV SHALL not change them until FIX.
- REQ-025: done and start at the same edge in IDLE SHALL accept the new op normally.

Reset
- REQ-026: reset=1 SHALL at next edge force IDLE, busy=0, done=0, hi=0, lo=0, counter=0, overriding start.
- REQ-027: reset mid-operation SHALL abort it; no partial result reaches HI/LO.

Configuration
- REQ-028: Macro MDU_DIV_EN defined SHALL include the divider datapath and DIV state; DIV/DIVU behave per REQ-018..020.
- REQ-029: MDU_DIV_EN undefined SHALL omit divider logic; DIV/DIVU treated as reserved ops per REQ-022; MULT/MTHI/MTLO unchanged.

Verification
- REQ-030: MULT rs=0xFFFFFFFF rt=0x00000002 -> busy edges 0..33, done cycle after edge 33, hi=0xFFFFFFFF lo=0xFFFFFFFE.
- REQ-031: MULTU rs=0xFFFFFFFF rt=0xFFFFFFFF -> hi=0xFFFFFFFE lo=0x00000001.
- REQ-032: DIV rs=0xFFFFFFF9 (-7) rt=0x00000002 -> lo=0xFFFFFFFD hi=0xFFFFFFFF; DIVU rs=0x10 rt=0 -> lo=0xFFFFFFFF hi=0x10.
- REQ-033: MTHI rs=0x12345678 then MTLO rs=0x9ABCDEF0 -> hi/lo updated same edge, busy=0, done=0 throughout.
- REQ-034: MULT 3*4, second start (DIVU) at edge 10, reset at edge 20 of a third op -> second ignored, first gives hi=0 lo=0xC; after reset busy=0 done=0 hi=lo=0.
- REQ-035: Build without MDU_DIV_EN, DIV 8/2 -> busy never asserts, hi/lo unchanged.
